// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage between EX/MEM and MEM/WB.
// Non-memory ops pass straight through. Loads and stores run a request/ack
// bus transaction and stall the pipeline until the result is formatted.
module mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  exp_no_i,
  input  logic [31:0] exp_retpc_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [7:0]  exp_no_o,
  output logic [31:0] exp_retpc_o,
  output logic        stallreq_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  input  logic        bus_err_i
);

  localparam logic [7:0] OP_LB    = 8'h20;
  localparam logic [7:0] OP_LH    = 8'h21;
  localparam logic [7:0] OP_LW    = 8'h23;
  localparam logic [7:0] OP_LBU   = 8'h24;
  localparam logic [7:0] OP_LHU   = 8'h25;
  localparam logic [7:0] OP_SB    = 8'h28;
  localparam logic [7:0] OP_SH    = 8'h29;
  localparam logic [7:0] OP_SW    = 8'h2B;
  localparam logic [7:0] EXP_GP   = 8'h0D;
  localparam logic [7:0] EXP_AC   = 8'h11;
  localparam logic [7:0] EXP_NONE = 8'hFF;
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [1:0]  addrLo_q, addrLo_d;
  logic [4:0]  wd_q, wd_d;
  logic [31:0] retpc_q, retpc_d;
  logic [7:0]  exp_q, exp_d;
  logic [31:0] result_q, result_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cntNext;
  logic        busCyc_q, busCyc_d;
  logic        busWe_q, busWe_d;
  logic [3:0]  busSel_q, busSel_d;
  logic [31:0] busAddr_q, busAddr_d;
  logic [31:0] busWdata_q, busWdata_d;
  logic        acceptMem;
  logic        leaveBusy;

  function automatic logic isByte(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
  endfunction

  function automatic logic isHalf(input logic [7:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic isWord(input logic [7:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic isLoad(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic isStore(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [3:0] laneSel(input logic [7:0] op, input logic [1:0] a);
    if (isByte(op)) return 4'b0001 << a;
    if (isHalf(op)) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] storeData(input logic [7:0] op, input logic [31:0] d);
    if (op == OP_SB) return {4{d[7:0]}};
    if (op == OP_SH) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [31:0] loadFormat(input logic [7:0] op, input logic [1:0] a,
                                             input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'd0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'd0, h};
      OP_LW:   return rd;
      default: return 32'd0;
    endcase
  endfunction

  assign acceptMem = (isLoad(aluop_i) || isStore(aluop_i)) && (exp_no_i == EXP_NONE);
  assign cntNext   = cnt_q + 8'd1;
  assign leaveBusy = flush || bus_err_i || bus_ack_i || (cntNext == TIMEOUT_LIMIT);

  // State and captured-transaction registers; async reset drops bus strobes at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= 8'd0;
      addrLo_q   <= 2'd0;
      wd_q       <= 5'd0;
      retpc_q    <= 32'd0;
      exp_q      <= EXP_NONE;
      result_q   <= 32'd0;
      cnt_q      <= 8'd0;
      busCyc_q   <= 1'b0;
      busWe_q    <= 1'b0;
      busSel_q   <= 4'd0;
      busAddr_q  <= 32'd0;
      busWdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addrLo_q   <= addrLo_d;
      wd_q       <= wd_d;
      retpc_q    <= retpc_d;
      exp_q      <= exp_d;
      result_q   <= result_d;
      cnt_q      <= cnt_d;
      busCyc_q   <= busCyc_d;
      busWe_q    <= busWe_d;
      busSel_q   <= busSel_d;
      busAddr_q  <= busAddr_d;
      busWdata_q <= busWdata_d;
    end
  end

  // Next-state logic: capture in IDLE, resolve ack/err/timeout/flush in BUSY.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addrLo_d   = addrLo_q;
    wd_d       = wd_q;
    retpc_d    = retpc_q;
    exp_d      = exp_q;
    result_d   = result_q;
    cnt_d      = cnt_q;
    busCyc_d   = busCyc_q;
    busWe_d    = busWe_q;
    busSel_d   = busSel_q;
    busAddr_d  = busAddr_q;
    busWdata_d = busWdata_q;
    case (state_q)
      IDLE: begin
        if (!flush && acceptMem) begin
          op_d     = aluop_i;
          addrLo_d = addr_i[1:0];
          wd_d     = wd_i;
          retpc_d  = exp_retpc_i;
          result_d = 32'd0;
          cnt_d    = 8'd0;
          if ((isHalf(aluop_i) && addr_i[0]) || (isWord(aluop_i) && (addr_i[1:0] != 2'b00))) begin
            exp_d   = EXP_AC;
            state_d = DONE;
          end else begin
            exp_d      = EXP_NONE;
            state_d    = BUSY;
            busCyc_d   = 1'b1;
            busWe_d    = isStore(aluop_i);
            busSel_d   = laneSel(aluop_i, addr_i[1:0]);
            busAddr_d  = {addr_i[31:2], 2'b00};
            busWdata_d = storeData(aluop_i, data_i);
          end
        end
      end
      BUSY: begin
        cnt_d = cntNext;
        if (leaveBusy) begin
          busCyc_d   = 1'b0;
          busWe_d    = 1'b0;
          busSel_d   = 4'd0;
          busAddr_d  = 32'd0;
          busWdata_d = 32'd0;
        end
        if (flush) begin
          state_d = IDLE;
        end else if (bus_err_i) begin
          exp_d   = EXP_GP;
          state_d = DONE;
        end else if (bus_ack_i) begin
          result_d = loadFormat(op_q, addrLo_q, bus_rdata_i);
          state_d  = DONE;
        end else if (cntNext == TIMEOUT_LIMIT) begin
          exp_d   = EXP_GP;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output mux: pass-through when idle, hold/stall while busy, present result when done.
  always_comb begin
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    exp_no_o    = exp_no_i;
    exp_retpc_o = exp_retpc_i;
    stallreq_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (acceptMem) begin
          stallreq_o = 1'b1;
          wreg_o     = 1'b0;
          exp_no_o   = EXP_NONE;
        end
      end
      BUSY: begin
        wd_o        = wd_q;
        wreg_o      = 1'b0;
        wdata_o     = 32'd0;
        exp_no_o    = EXP_NONE;
        exp_retpc_o = retpc_q;
        stallreq_o  = 1'b1;
      end
      default: begin
        wd_o        = wd_q;
        wreg_o      = isLoad(op_q) && (exp_q == EXP_NONE);
        wdata_o     = result_q;
        exp_no_o    = exp_q;
        exp_retpc_o = retpc_q;
      end
    endcase
    if (flush) begin
      wreg_o     = 1'b0;
      exp_no_o   = EXP_NONE;
      stallreq_o = 1'b0;
    end
  end

  assign bus_cyc_o   = busCyc_q;
  assign bus_stb_o   = busCyc_q;
  assign bus_we_o    = busWe_q;
  assign bus_sel_o   = busSel_q;
  assign bus_addr_o  = busAddr_q;
  assign bus_wdata_o = busWdata_q;

endmodule
